rf_conv_scheduler: RTL and testbench
====================================

// Module: rf_conv_scheduler
// PURPOSE
// Frame-level sequencer for one convolution pass: loads ARRAYLEN kernel weights into the
// systolic array, then streams a FIG_WIDTH x FIG_WIDTH raster feature map through the
// receptive-field serializer and flags which serializer outputs are complete windows.
// Sits between feature/weight memories and the serializer + systolic array; owns all flow control.
// PARAMETERS
// WORDWIDTH   32  data word width
// FIG_WIDTH   28  feature-map side length (square, raster order, stride 1, no padding)
// WEIGHTLEN   5   kernel side length
// ARRAYLEN    25  kernel words = WEIGHTLEN*WEIGHTLEN
// FIG_ADDRLEN 5   row/col counter width, >= clog2(FIG_WIDTH)
// SER_LAT     1   serializer latency, cycles from accepted in_valid beat to its window
// PORTS
// clk          in   1          clock, all logic on posedge
// rst          in   1          synchronous, active-high reset
// start        in   1          one-cycle pulse: begin a pass (ignored unless IDLE)
// w_data       in   WORDWIDTH  weight word from weight memory
// w_valid      in   1          weight word available
// w_ready      out  1          weight accepted when w_valid & w_ready
// w_load       out  1          write w_load_data into array slot w_idx this cycle
// w_load_data  out  WORDWIDTH  registered copy of accepted w_data
// w_idx        out  5          array weight slot 0..ARRAYLEN-1
// s_data       in   WORDWIDTH  feature pixel, raster order
// s_valid      in   1          pixel available
// s_ready      out  1          pixel accepted when s_valid & s_ready
// array_ready  in   1          systolic array can take a window this cycle
// ser_din      out  WORDWIDTH  serializer din (s_data, passed through combinationally)
// ser_in_valid out  1          serializer in_valid = s_valid & s_ready
// win_valid    out  1          serializer dout is a complete window for the array
// win_row      out  FIG_ADDRLEN output-map row of current window
// win_col      out  FIG_ADDRLEN output-map column of current window
// busy         out  1          high in every state except IDLE
// done         out  1          one-cycle pulse when pass completes
// BEHAVIOUR
// Reset: state=IDLE; all counters 0; w_ready, s_ready, w_load, win_valid, busy, done = 0;
//   w_load_data, w_idx, win_row, win_col = 0; SER_LAT tag pipeline cleared. Mid-pass reset aborts.
// FSM: IDLE -start-> LOAD_W; LOAD_W -ARRAYLEN-th weight accepted-> STREAM;
//   STREAM -FIG_WIDTH^2-th pixel accepted-> DRAIN; DRAIN -SER_LAT cycles-> DONE; DONE -> IDLE.
// start during non-IDLE ignored. done high exactly the DONE cycle; busy low in IDLE only.
// LOAD_W: w_ready=1; each handshake registers w_load=1, w_load_data, w_idx=k (k=0..24) next cycle.
// STREAM: s_ready = array_ready (array stall freezes serializer; no beat lost). Counters
//   row/col advance per accepted pixel; col wraps FIG_WIDTH-1 -> 0 and increments row.
// Window tag per accepted pixel: full = (row>=WEIGHTLEN-1)&&(col>=WEIGHTLEN-1);
//   win_row=row-(WEIGHTLEN-1), win_col=col-(WEIGHTLEN-1). Tag delayed SER_LAT cycles so
//   win_valid/win_row/win_col align with serializer dout; win_valid=0 for non-full tags.
// Windows per pass = (FIG_WIDTH-WEIGHTLEN+1)^2 = 576 default; last window (23,23).
// s_valid with array_ready=0: s_ready=0, counters hold. s_valid outside STREAM: never accepted.
// w_valid outside LOAD_W: never accepted. Counters are exact-width; no overflow reachable.
// DRAIN: s_ready=0; in-flight tags still emitted. Counters reset to 0 on DONE for next pass.
// STRUCTURE
// Shared package: FSM state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE), derived constants
//   FIG_PIXELS, OUT_WIDTH=FIG_WIDTH-WEIGHTLEN+1, WIN_COUNT.
// One sub-module: rf_tag_pipe (SER_LAT-deep shift register of {full,row,col}, clears on rst).
// TESTING
// Reset mid-STREAM (pixel 300) -> next cycle state IDLE, busy=0, no win_valid; fresh start runs full pass.
// start, 25 weights w_valid=1 -> w_load 25 cycles, w_idx 0..24, w_load_data matches input.
// Full pass, array_ready=1 -> 784 pixels in 784 cycles, 576 win_valid, first (0,0) at pixel 116+SER_LAT, last (23,23).
// array_ready toggling 50% random -> same 576 windows in order, no dropped/duplicated pixel, s_ready==array_ready.
// start pulsed during STREAM and w_valid during STREAM -> both ignored, counts unchanged.
// done single-cycle SER_LAT+1 cycles after last pixel; busy falls with it; back-to-back pass correct.

Source files
------------

// File: rtl/rf_conv_scheduler_pkg.sv
// rf_conv_scheduler_pkg: shared constants, FSM state enum and window tag type for the convolution scheduler
package rf_conv_scheduler_pkg;
    localparam int WORDWIDTH   = 32;
    localparam int FIG_WIDTH   = 28;
    localparam int WEIGHTLEN   = 5;
    localparam int ARRAYLEN    = 25;
    localparam int FIG_ADDRLEN = 5;
    localparam int SER_LAT     = 1;
    localparam int FIG_PIXELS  = FIG_WIDTH * FIG_WIDTH;
    localparam int OUT_WIDTH   = FIG_WIDTH - WEIGHTLEN + 1;
    localparam int WIN_COUNT   = OUT_WIDTH * OUT_WIDTH;
    localparam int DRAIN_W     = $clog2(SER_LAT + 1);
    localparam logic [FIG_ADDRLEN-1:0] EDGE = FIG_ADDRLEN'(FIG_WIDTH - 1);
    localparam logic [FIG_ADDRLEN-1:0] KOFF = FIG_ADDRLEN'(WEIGHTLEN - 1);
    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
    typedef struct packed {
        logic                   full;
        logic [FIG_ADDRLEN-1:0] row;
        logic [FIG_ADDRLEN-1:0] col;
    } tag_t;
endpackage

// File: rtl/rf_conv_scheduler_if.sv
// rf_conv_scheduler_if: control, weight, pixel and window signals between memories, scheduler and array
interface rf_conv_scheduler_if;
    import rf_conv_scheduler_pkg::*;
    logic                   start;
    logic [WORDWIDTH-1:0]   w_data;
    logic                   w_valid;
    logic                   w_ready;
    logic                   w_load;
    logic [WORDWIDTH-1:0]   w_load_data;
    logic [4:0]             w_idx;
    logic [WORDWIDTH-1:0]   s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   array_ready;
    logic [WORDWIDTH-1:0]   ser_din;
    logic                   ser_in_valid;
    logic                   win_valid;
    logic [FIG_ADDRLEN-1:0] win_row;
    logic [FIG_ADDRLEN-1:0] win_col;
    logic                   busy;
    logic                   done;
    modport master (
        output start, w_data, w_valid, s_data, s_valid, array_ready,
        input  w_ready, w_load, w_load_data, w_idx, s_ready, ser_din, ser_in_valid,
               win_valid, win_row, win_col, busy, done
    );
    modport slave (
        input  start, w_data, w_valid, s_data, s_valid, array_ready,
        output w_ready, w_load, w_load_data, w_idx, s_ready, ser_din, ser_in_valid,
               win_valid, win_row, win_col, busy, done
    );
endinterface

// File: rtl/rf_conv_scheduler_tag_pipe.sv
// rf_tag_pipe: delays window tags by the serializer latency so they line up with its output
module rf_tag_pipe
    import rf_conv_scheduler_pkg::*;
#(
    parameter int DEPTH = SER_LAT
) (
    input  logic clk,
    input  logic rst,
    input  tag_t d,
    output tag_t q
);
    tag_t stage [DEPTH];

    // shift one stage per cycle; empty cycles carry a non-full tag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/rf_conv_scheduler.sv
// rf_conv_scheduler: loads kernel weights, then streams one feature map and tags complete receptive-field windows
module rf_conv_scheduler
    import rf_conv_scheduler_pkg::*;
(
    input logic                clk,
    input logic                rst,
    rf_conv_scheduler_if.slave bus
);
    state_t                 state, state_n;
    logic [4:0]             w_cnt;
    logic [FIG_ADDRLEN-1:0] row, col;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   w_hs, s_hs, last_w, last_px, drain_end;
    tag_t                   tag_in, tag_out;

    assign bus.w_ready      = state == LOAD_W;
    assign bus.s_ready      = state == STREAM && bus.array_ready;
    assign bus.ser_din      = bus.s_data;
    assign bus.ser_in_valid = s_hs;
    assign bus.busy         = state != IDLE;
    assign bus.done         = state == DONE;
    assign w_hs      = bus.w_valid && bus.w_ready;
    assign s_hs      = bus.s_valid && bus.s_ready;
    assign last_w    = w_cnt == 5'(ARRAYLEN - 1);
    assign last_px   = row == EDGE && col == EDGE;
    assign drain_end = drain_cnt == DRAIN_W'(SER_LAT - 1);

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? LOAD_W : IDLE;
            LOAD_W:  state_n = (w_hs && last_w) ? STREAM : LOAD_W;
            STREAM:  state_n = (s_hs && last_px) ? DRAIN : STREAM;
            DRAIN:   state_n = drain_end ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // weight, raster and drain counters; cleared on DONE so the next pass starts at zero
    always_ff @(posedge clk) begin
        if (rst || state == DONE) begin
            w_cnt     <= '0;
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
        end else begin
            if (w_hs) w_cnt <= w_cnt + 5'd1;
            if (s_hs) begin
                col <= (col == EDGE) ? '0 : col + FIG_ADDRLEN'(1);
                if (col == EDGE) row <= row + FIG_ADDRLEN'(1);
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
    end

    // registered weight write port into the array
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.w_load      <= 1'b0;
            bus.w_load_data <= '0;
            bus.w_idx       <= '0;
        end else begin
            bus.w_load <= w_hs;
            if (w_hs) begin
                bus.w_load_data <= bus.w_data;
                bus.w_idx       <= w_cnt;
            end
        end
    end

    assign tag_in = '{full: s_hs && row >= KOFF && col >= KOFF, row: row - KOFF, col: col - KOFF};

    rf_tag_pipe #(.DEPTH(SER_LAT)) u_tag_pipe (
        .clk (clk),
        .rst (rst),
        .d   (tag_in),
        .q   (tag_out)
    );

    assign bus.win_valid = tag_out.full;
    assign bus.win_row   = tag_out.row;
    assign bus.win_col   = tag_out.col;
endmodule

// File: tb/tb_rf_conv_scheduler.sv
// tb_rf_conv_scheduler: directed passes checking weight load, window order/latency, stalls, reset abort and done timing
module tb_rf_conv_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int pix_seen, win_cnt, wl_cnt, done_cnt, prev_acc, last_r, last_c;
    logic [31:0] w_base = 32'h0;

    always #5 clk = ~clk;

    rf_conv_scheduler_if bus ();

    rf_conv_scheduler u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: window order and one-cycle alignment to its pixel, pixel sequence, weight writes, done pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.win_valid) begin
                check("win_row", 32'(bus.win_row), win_cnt / 24);
                check("win_col", 32'(bus.win_col), win_cnt % 24);
                check("win_lat", prev_acc, (win_cnt / 24 + 4) * 28 + win_cnt % 24 + 4);
                last_r = int'(bus.win_row);
                last_c = int'(bus.win_col);
                win_cnt++;
            end
            prev_acc = bus.ser_in_valid ? pix_seen : -1;
            if (bus.ser_in_valid) begin
                check("pix_data", bus.ser_din, pix_seen);
                pix_seen++;
            end
            if (bus.w_load) begin
                check("w_idx", 32'(bus.w_idx), wl_cnt);
                check("w_data", bus.w_load_data, w_base + wl_cnt);
                wl_cnt++;
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        pix_seen = 0;
        win_cnt  = 0;
        wl_cnt   = 0;
        done_cnt = 0;
        prev_acc = -1;
        last_r   = -1;
        last_c   = -1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic load_weights(input logic [31:0] base);
        int k = 0;
        int cyc = 0;
        while (k < 25 && cyc < 200) begin
            bus.w_valid = 1'b1;
            bus.w_data  = base + k;
            @(negedge clk);
            if (bus.w_ready) k++;
            cyc++;
            tick();
        end
        check("w_cycles", cyc, 25);
    endtask

    task automatic stream(input bit rnd, input int stop_at, output int cyc);
        int pix = 0;
        cyc = 0;
        while (pix < stop_at && cyc < 5000) begin
            bus.array_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid     = 1'b1;
            bus.s_data      = pix;
            bus.start       = (pix == 400);
            @(negedge clk);
            check("s_ready", 32'(bus.s_ready), 32'(bus.array_ready));
            if (bus.s_ready) pix++;
            cyc++;
            tick();
        end
        bus.start = 1'b0;
        if (pix < stop_at) check("stream_timeout", pix, stop_at);
    endtask

    task automatic finish_pass();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 50);
        check("done_lat", n, 2);
        check("busy_done", 32'(bus.busy), 1);
        tick();
        @(negedge clk);
        check("done_single", 32'(bus.done), 0);
        check("busy_idle", 32'(bus.busy), 0);
        check("done_cnt", done_cnt, 1);
        check("win_cnt", win_cnt, 576);
        check("pix_cnt", pix_seen, 784);
        check("wl_cnt", wl_cnt, 25);
        check("last_row", last_r, 23);
        check("last_col", last_c, 23);
    endtask

    task automatic full_pass(input bit rnd, input logic [31:0] base);
        int cyc;
        clear_sb();
        w_base      = base;
        bus.w_valid = 1'b1;
        bus.w_data  = base;
        pulse_start();
        load_weights(base);
        stream(rnd, 784, cyc);
        if (!rnd) check("stream_cycles", cyc, 784);
        finish_pass();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.start       = 1'b0;
        bus.w_valid     = 1'b1;
        bus.w_data      = 32'h1234;
        bus.s_valid     = 1'b1;
        bus.s_data      = 32'h0;
        bus.array_ready = 1'b1;
        clear_sb();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_w_ready", 32'(bus.w_ready), 0);
        check("rst_s_ready", 32'(bus.s_ready), 0);
        check("rst_w_load", 32'(bus.w_load), 0);
        check("rst_win_valid", 32'(bus.win_valid), 0);
        check("rst_w_idx", 32'(bus.w_idx), 0);
        check("rst_w_load_data", bus.w_load_data, 0);
        check("rst_win_row", 32'(bus.win_row), 0);
        check("rst_win_col", 32'(bus.win_col), 0);
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_w_ready", 32'(bus.w_ready), 0);
        check("idle_s_ready", 32'(bus.s_ready), 0);
        check("idle_no_wload", wl_cnt, 0);
        check("idle_no_pix", pix_seen, 0);
        tick();

        full_pass(1'b0, 32'hA000_0000);
        full_pass(1'b1, 32'hB000_0000);

        clear_sb();
        w_base = 32'hD000_0000;
        pulse_start();
        load_weights(32'hD000_0000);
        stream(1'b0, 300, cyc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_win_valid", 32'(bus.win_valid), 0);
        check("abort_s_ready", 32'(bus.s_ready), 0);
        check("abort_w_ready", 32'(bus.w_ready), 0);
        clear_sb();
        repeat (3) tick();
        check("abort_no_pix", pix_seen, 0);
        check("abort_no_win", win_cnt, 0);

        full_pass(1'b0, 32'hC000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
